// File: rtl/sgf_div_seq_pkg.sv
// Shared types and width helpers for the
// sequential significand divider.
package sgf_div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int quot_w(input int sw);
    return sw + 2;
  endfunction

  function automatic int cnt_w(input int sw);
    return $clog2(sw + 2);
  endfunction

endpackage

// File: rtl/sgf_div_seq_step.sv
// One radix-2 restoring step: compare,
// conditionally subtract, shift left.
module div_step #(
  parameter int SW = 54
) (
  input  logic [SW:0]   i_rem,
  input  logic [SW-1:0] i_div,
  output logic          o_q,
  output logic          o_rem_nz,
  output logic [SW:0]   o_rem_nxt
);

  logic [SW:0] w_div_ext;
  logic [SW:0] w_diff;

  assign w_div_ext = {1'b0, i_div};
  assign o_q       = (i_rem >= w_div_ext);
  assign w_diff    = o_q ? (i_rem - w_div_ext)
                         : i_rem;
  // Restored remainder is below B, so the
  // top bit is always zero and the shift is lossless.
  assign o_rem_nxt = {w_diff[SW-1:0], 1'b0};
  assign o_rem_nz  = |w_diff;

endmodule

// File: rtl/sgf_div_seq.sv
// Sequential radix-2 restoring divider for
// FPU significands, one quotient bit per clock.
module sgf_div_seq
  import sgf_div_seq_pkg::*;
#(
  parameter int SW = 54
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [SW-1:0]      Data_A_i,
  input  logic [SW-1:0]      Data_B_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [SW+1:0]      sgf_quot_o,
  output logic               sticky_o,
  output logic               div_zero_o
);

  localparam int QW = quot_w(SW);
  localparam int CW = cnt_w(SW);

  state_t r_state;
  state_t w_state_nxt;

  logic [SW:0]   r_rem;
  logic [SW-1:0] r_div;
  logic [QW-1:0] r_quot;
  logic [CW-1:0] r_cnt;
  logic          r_sticky;
  logic          r_dz;

  logic          w_accept;
  logic          w_bzero;
  logic          w_last;
  logic          w_q;
  logic          w_rem_nz;
  logic [SW:0]   w_rem_nxt;

  assign w_accept = load_i && (r_state != ST_RUN);
  assign w_bzero  = (Data_B_i == '0);
  assign w_last   = (r_cnt == '0);

  div_step #(.SW(SW)) u_step (
    .i_rem     (r_rem),
    .i_div     (r_div),
    .o_q       (w_q),
    .o_rem_nz  (w_rem_nz),
    .o_rem_nxt (w_rem_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept)
          w_state_nxt = w_bzero ? ST_DONE : ST_RUN;
        else
          w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_div    <= '0;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_div    <= Data_B_i;
      r_rem    <= {1'b0, Data_A_i};
      r_quot   <= w_bzero ? '1 : '0;
      r_cnt    <= CW'(QW - 1);
      r_sticky <= 1'b0;
      r_dz     <= w_bzero;
    end else if (r_state == ST_RUN) begin
      r_rem  <= w_rem_nxt;
      r_quot <= {r_quot[QW-2:0], w_q};
      if (w_last) r_sticky <= w_rem_nz;
      else        r_cnt    <= r_cnt - 1'b1;
    end
  end

  assign ready_o    = (r_state == ST_IDLE) ||
                      (r_state == ST_DONE);
  assign valid_o    = (r_state == ST_DONE);
  assign sgf_quot_o = r_quot;
  assign sticky_o   = r_sticky;
  assign div_zero_o = r_dz;

endmodule

// File: tb/tb_sgf_div_seq.sv
// Scoreboard bench for sgf_div_seq at SW=8:
// directed loads, monitor pops on valid_o.
module tb_sgf_div_seq;

  localparam int SW = 8;
  localparam int QW = SW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_i = 1'b0;
  logic [SW-1:0] Data_A_i = '0;
  logic [SW-1:0] Data_B_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [QW-1:0] sgf_quot_o;
  logic          sticky_o;
  logic          div_zero_o;

  typedef struct {
    logic [QW-1:0] quot;
    logic          sticky;
    logic          dz;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  sgf_div_seq #(.SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_i),
    .Data_A_i   (Data_A_i),
    .Data_B_i   (Data_B_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .sgf_quot_o (sgf_quot_o),
    .sticky_o   (sticky_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got quot %0h want none",
                 sgf_quot_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", 32'(sgf_quot_o), 32'(e.quot));
        chk("sticky", 32'(sticky_o), 32'(e.sticky));
        chk("div_zero", 32'(div_zero_o), 32'(e.dz));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a load for one edge; push the expected
  // result when exp_push is set.
  task automatic issue(input logic [SW-1:0] a,
                       input logic [SW-1:0] b,
                       input logic [QW-1:0] q,
                       input logic st,
                       input logic dz,
                       input logic exp_push);
    exp_t e;
    Data_A_i = a;
    Data_B_i = b;
    load_i   = 1'b1;
    if (exp_push) begin
      e.quot   = q;
      e.sticky = st;
      e.dz     = dz;
      e.cyc    = cyc + 1 + (dz ? 0 : QW);
      sb.push_back(e);
    end
    tick();
    load_i = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %0d pending want 0",
               nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!valid_o && n < 40) begin
      tick();
      n++;
    end
    if (!valid_o) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got valid 0 want 1", nm);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_quot"}, 32'(sgf_quot_o), 32'h0);
    chk({nm, "_sticky"}, 32'(sticky_o), 32'h0);
    chk({nm, "_dz"}, 32'(div_zero_o), 32'h0);
    chk({nm, "_valid"}, 32'(valid_o), 32'h0);
    chk({nm, "_ready"}, 32'(ready_o), 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();

    issue(8'h80, 8'h80, 10'h200, 1'b0, 1'b0, 1'b1);
    chk("busy_ready", 32'(ready_o), 32'h0);
    wait_empty("one");

    issue(8'hC0, 8'h80, 10'h300, 1'b0, 1'b0, 1'b1);
    wait_empty("c0_80");

    issue(8'h80, 8'hC0, 10'h155, 1'b1, 1'b0, 1'b1);
    wait_empty("80_c0");

    issue(8'hFF, 8'h00, 10'h3FF, 1'b0, 1'b1, 1'b1);
    wait_empty("dz");

    // Back-to-back load on the valid cycle, then
    // a stray load mid-run that must be ignored.
    issue(8'h80, 8'h80, 10'h200, 1'b0, 1'b0, 1'b1);
    wait_valid("b2b");
    issue(8'h80, 8'hC0, 10'h155, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    issue(8'hFF, 8'h01, 10'h000, 1'b0, 1'b0, 1'b0);
    wait_empty("b2b");

    // Divide-by-zero followed immediately by a load.
    issue(8'hFF, 8'h00, 10'h3FF, 1'b0, 1'b1, 1'b1);
    issue(8'hC0, 8'h80, 10'h300, 1'b0, 1'b0, 1'b1);
    wait_empty("dz_b2b");

    // Reset lands on the fourth RUN edge.
    issue(8'hC0, 8'h80, 10'h300, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midrst");
    repeat (15) tick();

    issue(8'hC0, 8'h80, 10'h300, 1'b0, 1'b0, 1'b1);
    wait_empty("post_rst");

    chk("idle_ready", 32'(ready_o), 32'h1);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
